ifetch_unit: RTL and testbench

//  Instruction fetch stage. Owns the PC, drives the address port of the synchronous-read

---
 rtl/ifetch_unit.sv | 191 +++++++++++++++++++
 tb/tb_ifetch_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// -----------------------------------------------------------------------------
// ifetch_unit
//
// Instruction fetch stage. Owns the program counter and drives the address
// port of a synchronous-read instruction memory (one cycle read latency). The
// word coming back is presented to decode as {inst, inst_pc} over a
// valid/ready handshake. A single-entry skid buffer holds a returned word while
// decode stalls, so nothing in flight is lost. A redirect flushes the skid
// buffer and the in-flight fetch and restarts at the new address.
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst             synchronous reset, active-high
//   imem_addr       address to instruction memory (combinational)
//   imem_we         memory write enable, always 0
//   imem_dout       memory read data, valid one cycle after the address
//   halt            1 = issue no new fetches; pending words still drain
//   redirect_valid  taken branch/jump: flush and restart at redirect_pc
//   redirect_pc     restart address
//   inst_valid      inst/inst_pc valid to decode
//   inst_ready      decode accepts when inst_valid & inst_ready
//   inst            instruction word
//   inst_pc         address of inst
// -----------------------------------------------------------------------------
module ifetch_unit #(
    parameter int unsigned     AW     = 16,
    parameter int unsigned     DW     = 16,
    parameter logic [AW-1:0]   RST_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] imem_addr,
    output logic          imem_we,
    input  logic [DW-1:0] imem_dout,
    input  logic          halt,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_pc,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [DW-1:0] inst,
    output logic [AW-1:0] inst_pc
);

    localparam logic [AW-1:0] PC_ONE = AW'(1);

    // Next address to issue.
    logic [AW-1:0] pc_q;
    logic [AW-1:0] pc_d;
    // Fetch issued last cycle; its data is on imem_dout now.
    logic          req_v_q;
    logic          req_v_d;
    logic [AW-1:0] req_pc_q;
    logic [AW-1:0] req_pc_d;
    // Word held while decode is stalled.
    logic          skid_v_q;
    logic          skid_v_d;
    logic [AW-1:0] skid_pc_q;
    logic [AW-1:0] skid_pc_d;
    logic [DW-1:0] skid_inst_q;
    logic [DW-1:0] skid_inst_d;

    // A new fetch may go out only if nothing is parked in the skid buffer
    // and the word currently returning will be consumed this cycle.
    logic          issue;

    // The memory is only ever read; holding we low keeps its address register
    // updating every cycle.
    assign imem_we = 1'b0;

    // Issue decision; depends combinationally on inst_ready by design.
    always_comb begin
        issue = 1'b0;
        if (halt) begin
            issue = 1'b0;
        end else if (skid_v_q) begin
            issue = 1'b0;
        end else begin
            issue = ~req_v_q | inst_ready;
        end
    end

    // Memory address: reset vector, redirect target, or the current PC.
    always_comb begin
        imem_addr = pc_q;
        if (rst) begin
            imem_addr = RST_PC;
        end else if (redirect_valid) begin
            imem_addr = redirect_pc;
        end else begin
            imem_addr = pc_q;
        end
    end

    // Output mux: the skid buffer always holds the older word, so it wins.
    always_comb begin
        inst    = imem_dout;
        inst_pc = req_pc_q;
        if (skid_v_q) begin
            inst    = skid_inst_q;
            inst_pc = skid_pc_q;
        end else begin
            inst    = imem_dout;
            inst_pc = req_pc_q;
        end
    end

    // Valid to decode; suppressed during reset and in a redirect cycle so a
    // stale word can never be accepted.
    always_comb begin
        inst_valid = 1'b0;
        if (rst) begin
            inst_valid = 1'b0;
        end else if (redirect_valid) begin
            inst_valid = 1'b0;
        end else begin
            inst_valid = skid_v_q | req_v_q;
        end
    end

    // Next-state logic for PC, in-flight request and skid buffer.
    always_comb begin
        pc_d        = pc_q;
        req_v_d     = req_v_q;
        req_pc_d    = req_pc_q;
        skid_v_d    = skid_v_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;

        if (redirect_valid) begin
            // Flush: drop the held word and whatever is returning now.
            skid_v_d = 1'b0;
            if (halt) begin
                req_v_d = 1'b0;
                pc_d    = redirect_pc;
            end else begin
                req_v_d  = 1'b1;
                req_pc_d = redirect_pc;
                pc_d     = redirect_pc + PC_ONE;
            end
        end else begin
            if (issue) begin
                req_v_d  = 1'b1;
                req_pc_d = pc_q;
                pc_d     = pc_q + PC_ONE;
            end else begin
                // The read result for pc_q is ignored; pc_q is re-issued later.
                req_v_d  = 1'b0;
                req_pc_d = req_pc_q;
                pc_d     = pc_q;
            end

            if (skid_v_q) begin
                // While the skid is full no fetch is issued, so req_v_q is 0
                // here and the buffer only needs to drain.
                if (inst_ready) begin
                    skid_v_d = 1'b0;
                end else begin
                    skid_v_d = 1'b1;
                end
            end else if (req_v_q && !inst_ready) begin
                // Returning word not taken: park it, the memory will not
                // hold it for us next cycle.
                skid_v_d    = 1'b1;
                skid_pc_d   = req_pc_q;
                skid_inst_d = imem_dout;
            end else begin
                skid_v_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RST_PC;
            req_v_q     <= 1'b0;
            req_pc_q    <= RST_PC;
            skid_v_q    <= 1'b0;
            skid_pc_q   <= RST_PC;
            skid_inst_q <= '0;
        end else begin
            pc_q        <= pc_d;
            req_v_q     <= req_v_d;
            req_pc_q    <= req_pc_d;
            skid_v_q    <= skid_v_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// -----------------------------------------------------------------------------
// tb_ifetch_unit
//
// Self-checking bench for ifetch_unit. A synchronous memory model returns
// mem[k] = 0x0100 + k. The expected accepted {inst, inst_pc} stream is queued
// up front; a monitor pops and compares on every handshake. Directed checks
// cover reset, latency, stall stability, redirect flush, wrap, halt and reset
// during a stall.
// -----------------------------------------------------------------------------
module tb_ifetch_unit;

    logic        clk;
    logic        rst;
    logic [15:0] imem_addr;
    logic        imem_we;
    logic [15:0] imem_dout;
    logic        halt;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst;
    logic [15:0] inst_pc;

    int          n_pass;
    int          n_total;
    logic [31:0] exp_q[$];

    ifetch_unit #(
        .AW     (16),
        .DW     (16),
        .RST_PC (16'h0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_we        (imem_we),
        .imem_dout      (imem_dout),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory: mem[k] = 0x0100 + k
    always @(posedge clk) begin
        if (!imem_we) imem_dout <= 16'h0100 + imem_addr;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitor: every accepted word must be the next expected one
    always @(negedge clk) begin
        if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_xfer", {inst, inst_pc}, 32'hFFFF_FFFF);
            end else begin
                chk("xfer", {inst, inst_pc}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until pc is presented (checked at posedge+1), bounded
    task automatic wait_pc(input logic [15:0] pc);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (inst_valid && inst_pc == pc) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        if (!found) chk("wait_pc_timeout", {16'h0, inst_pc}, {16'h0, pc});
    endtask

    task automatic push(input logic [15:0] pc);
        logic [15:0] w;
        w = 16'h0100 + pc;
        exp_q.push_back({w, pc});
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        halt = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0000;
        inst_ready = 1'b1;

        // Expected accepted stream for the whole run
        for (int k = 0; k < 8; k++) push(16'(k));
        for (int k = 32; k < 36; k++) push(16'(k));
        push(16'hFFFF);
        for (int k = 0; k < 5; k++) push(16'(k));
        push(16'h0005);
        push(16'h0006);
        for (int k = 0; k < 3; k++) push(16'(k));

        // Reset state
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_valid", {31'h0, inst_valid}, 32'h0);
            chk("rst_addr", {16'h0, imem_addr}, 32'h0);
            chk("rst_we", {31'h0, imem_we}, 32'h0);
            tick();
        end

        // Release: issue addr 0, word 0 next cycle
        rst = 1'b0;
        @(negedge clk);
        chk("first_addr", {16'h0, imem_addr}, 32'h0);
        chk("first_valid", {31'h0, inst_valid}, 32'h0);
        tick();
        @(negedge clk);
        chk("lat_word0", {15'h0, inst_valid, inst}, {15'h0, 1'b1, 16'h0100});
        chk("lat_pc0", {16'h0, inst_pc}, 32'h0);

        // Stall 3 cycles at pc 5
        tick();
        wait_pc(16'h0005);
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_hold", {15'h0, inst_valid, inst}, {15'h0, 1'b1, 16'h0105});
            chk("stall_pc", {16'h0, inst_pc}, 32'h5);
            tick();
        end
        inst_ready = 1'b1;

        // Redirect to 0x0020 while skid holds word 8
        wait_pc(16'h0008);
        inst_ready = 1'b0;
        tick();
        chk("skid_full_pc", {15'h0, inst_valid, inst_pc}, {15'h0, 1'b1, 16'h0008});
        redirect_valid = 1'b1;
        redirect_pc = 16'h0020;
        @(negedge clk);
        chk("redir_valid", {31'h0, inst_valid}, 32'h0);
        chk("redir_addr", {16'h0, imem_addr}, 32'h20);
        tick();
        redirect_valid = 1'b0;
        inst_ready = 1'b1;
        @(negedge clk);
        chk("redir_word", {inst, inst_pc}, {16'h0120, 16'h0020});

        // Wrap: redirect to 0xFFFF, discarding presented 0x24
        tick();
        wait_pc(16'h0024);
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFF;
        @(negedge clk);
        chk("wrap_redir_valid", {31'h0, inst_valid}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("wrap_ffff", {15'h0, inst_valid, inst_pc}, {15'h0, 1'b1, 16'hFFFF});
        chk("wrap_ffff_inst", {16'h0, inst}, 32'h00FF);
        tick();
        @(negedge clk);
        chk("wrap_0000", {15'h0, inst_valid, inst_pc}, {15'h0, 1'b1, 16'h0000});

        // Halt the cycle after pc 3 is presented
        tick();
        wait_pc(16'h0003);
        tick();
        halt = 1'b1;
        @(negedge clk);
        chk("halt_word4", {15'h0, inst_valid, inst_pc}, {15'h0, 1'b1, 16'h0004});
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk("halt_idle", {15'h0, inst_valid, imem_addr}, {15'h0, 1'b0, 16'h0005});
        end
        tick();
        halt = 1'b0;
        @(negedge clk);
        chk("resume_addr", {16'h0, imem_addr}, 32'h5);
        tick();
        @(negedge clk);
        chk("resume_pc5", {15'h0, inst_valid, inst_pc}, {15'h0, 1'b1, 16'h0005});

        // Reset during stall with skid full
        tick();
        wait_pc(16'h0007);
        inst_ready = 1'b0;
        tick();
        chk("skid7", {15'h0, inst_valid, inst_pc}, {15'h0, 1'b1, 16'h0007});
        rst = 1'b1;
        @(negedge clk);
        chk("rst_stall_valid", {31'h0, inst_valid}, 32'h0);
        tick();
        rst = 1'b0;
        inst_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", {15'h0, inst_valid, imem_addr}, {15'h0, 1'b0, 16'h0000});
        tick();
        @(negedge clk);
        chk("post_rst_word", {inst, inst_pc}, {16'h0100, 16'h0000});

        // Drain the scoreboard, bounded
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        inst_ready = 1'b0;
        halt = 1'b1;
        chk("sb_empty", 32'(exp_q.size()), 32'h0);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
